regfile_write_sequencer: RTL

//  Write-side driver for the 32x32 register file: owns its rd/writedata/regwrite

---
 rtl/regfile_write_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/regfile_write_sequencer.sv
// Write-side sequencer for the 32x32 register file: arbitrates ALU/load
// writebacks into an in-order FIFO and retires one register write per cycle.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   alu_valid/alu_rd/alu_data     ALU writeback request, alu_ready handshake
//   ld_valid/ld_rd/ld_data        load writeback request, ld_ready handshake
//   rs, rt                        hazard query indices
//   rs_pending, rt_pending        write to rs/rt queued or being retired
//   rd, writedata, regwrite       registered register-file write port
//   count, full, empty            FIFO occupancy status
module regfile_write_sequencer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_rd,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        rs,
  input  logic [ADDR_W-1:0]        rt,
  output logic                     rs_pending,
  output logic                     rt_pending,
  output logic [ADDR_W-1:0]        rd,
  output logic [DATA_W-1:0]        writedata,
  output logic                     regwrite,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] r_q_rd   [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;

  logic              w_full;
  logic              w_empty;
  logic              w_acc_alu;
  logic              w_acc_ld;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_in_rd;
  logic [DATA_W-1:0] w_in_data;
  logic [DEPTH-1:0]  w_rs_q;
  logic [DEPTH-1:0]  w_rt_q;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // ALU has fixed priority; a load is only offered ready when no ALU
  // request is present, so at most one request is taken per cycle.
  assign alu_ready = !w_full;
  assign ld_ready  = !w_full && !alu_valid;

  assign w_acc_alu = alu_valid && alu_ready;
  assign w_acc_ld  = ld_valid && ld_ready;

  assign w_in_rd   = w_acc_alu ? alu_rd : ld_rd;
  assign w_in_data = w_acc_alu ? alu_data : ld_data;

  // Writes to r0 complete the handshake but never enter the queue.
  assign w_push = (w_acc_alu || w_acc_ld) && (w_in_rd != '0);
  assign w_pop  = !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wptr]   <= w_in_rd;
      r_q_data[r_wptr] <= w_in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rd    <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rd    <= r_q_rd[r_rptr];
        r_wdata <= r_q_data[r_rptr];
        r_we    <= 1'b1;
      end else begin
        r_we    <= 1'b0;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // An entry is live when its distance from the read pointer (mod DEPTH)
  // is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PW-1:0] w_off;
    logic          w_live;
    assign w_off     = PW'(g) - r_rptr;
    assign w_live    = ({1'b0, w_off} < r_count);
    assign w_rs_q[g] = w_live && (r_q_rd[g] == rs);
    assign w_rt_q[g] = w_live && (r_q_rd[g] == rt);
  end

  assign rs_pending = (rs != '0) &&
                      ((|w_rs_q) || (r_we && (r_rd == rs)));
  assign rt_pending = (rt != '0) &&
                      ((|w_rt_q) || (r_we && (r_rd == rt)));

  assign rd        = r_rd;
  assign writedata = r_wdata;
  assign regwrite  = r_we;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;

endmodule
